// File: rtl/adc_trigger_pkg.sv
// Shared types and state encodings for the multi-channel ADC level trigger.
package adc_trigger_pkg;

  typedef enum logic [1:0] {IDLE, PRETRIG, ARMED, HOLDOFF} trig_state_t;

  typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_RSVD} trig_edge_t;

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_PRETRIG = 2'd1;
  localparam logic [1:0] STATE_ARMED   = 2'd2;
  localparam logic [1:0] STATE_HOLDOFF = 2'd3;

endpackage

// File: rtl/adc_trigger_hyst_cmp.sv
// Hysteresis comparator: tracks a registered above-level flag and flags its transitions.
module adc_trigger_hyst_cmp #(
  parameter int unsigned SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] level,
  input  logic [SAMPLE_W-1:0] lo,
  output logic                hi,
  output logic                rise,
  output logic                fall
);

  logic hi_q, hi_d;
  logic vld_q, vld_d;

  always_comb begin
    hi_d  = hi_q;
    vld_d = vld_q;
    if (init) begin
      hi_d  = 1'b0;
      vld_d = 1'b0;
    end else if (valid) begin
      vld_d = 1'b1;
      if (sample >= level) begin
        hi_d = 1'b1;
      end else if (!vld_q || (sample < lo)) begin
        // First sample after init seeds the flag; afterwards only a drop below lo clears it.
        hi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      vld_q <= vld_d;
    end
  end

  assign hi   = hi_q;
  assign rise = valid && !init && vld_q && !hi_q && hi_d;
  assign fall = valid && !init && vld_q && hi_q && !hi_d;

endmodule

// File: rtl/adc_trigger_mc.sv
// Multi-channel ADC level trigger: channel select, arm/pretrig/armed/holdoff sequencing.
module adc_trigger_mc
  import adc_trigger_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned SAMPLE_W  = 8,
  parameter int unsigned PRETRIG_W = 16,
  parameter int unsigned HOLDOFF_W = 24,
  localparam int unsigned CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [NCH*SAMPLE_W-1:0] s_data,
  input  logic                    s_valid,
  input  logic                    cfg_arm,
  input  logic                    cfg_abort,
  input  logic                    cfg_force,
  input  logic                    cfg_rearm,
  input  logic [CH_W-1:0]         cfg_channel,
  input  logic [1:0]              cfg_edge,
  input  logic [SAMPLE_W-1:0]     cfg_level,
  input  logic [SAMPLE_W-1:0]     cfg_hyst,
  input  logic [PRETRIG_W-1:0]    cfg_pretrig,
  input  logic [HOLDOFF_W-1:0]    cfg_holdoff,
  output logic                    trig_out,
  output logic                    trig_forced,
  output logic [1:0]              state_out,
  output logic [31:0]             trig_count
);

  trig_state_t          state_q, state_d;
  trig_edge_t           edge_q;
  logic [CH_W-1:0]      ch_q;
  logic [SAMPLE_W-1:0]  level_q, hyst_q, lo, sample;
  logic [PRETRIG_W-1:0] pretrig_q, pre_cnt_q, pre_cnt_d;
  logic [HOLDOFF_W-1:0] holdoff_q, hold_cnt_q, hold_cnt_d;
  logic                 rearm_q, trig_q, trig_d, forced_q, forced_d;
  logic [31:0]          count_q;
  logic                 arm_ok, fire, edge_hit, cmp_hi, cmp_rise, cmp_fall;

  assign arm_ok = (state_q == IDLE) && cfg_arm && !cfg_abort;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ch_q      <= '0;
      edge_q    <= EDGE_RISE;
      level_q   <= '0;
      hyst_q    <= '0;
      pretrig_q <= '0;
      holdoff_q <= '0;
      rearm_q   <= 1'b0;
    end else if (arm_ok) begin
      ch_q      <= cfg_channel;
      edge_q    <= trig_edge_t'(cfg_edge);
      level_q   <= cfg_level;
      hyst_q    <= cfg_hyst;
      pretrig_q <= cfg_pretrig;
      holdoff_q <= cfg_holdoff;
      rearm_q   <= cfg_rearm;
    end
  end

  always_comb begin
    sample = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == k[CH_W-1:0]) sample = s_data[k*SAMPLE_W +: SAMPLE_W];
    end
  end

  assign lo = (level_q >= hyst_q) ? (level_q - hyst_q) : '0;

  adc_trigger_hyst_cmp #(
    .SAMPLE_W (SAMPLE_W)
  ) u_cmp (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .init   ((state_q == IDLE) || cfg_abort),
    .valid  (s_valid && (state_q != IDLE)),
    .sample (sample),
    .level  (level_q),
    .lo     (lo),
    .hi     (cmp_hi),
    .rise   (cmp_rise),
    .fall   (cmp_fall)
  );

  always_comb begin
    case (edge_q)
      EDGE_FALL: edge_hit = cmp_fall;
      EDGE_BOTH: edge_hit = cmp_rise || cmp_fall;
      default:   edge_hit = cmp_rise;
    endcase
  end

  assign fire = (state_q == ARMED) && !cfg_abort && ((s_valid && edge_hit) || cfg_force);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (cfg_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_arm) begin
            pre_cnt_d = '0;
            state_d   = (cfg_pretrig == '0) ? ARMED : PRETRIG;
          end
        end
        PRETRIG: begin
          if (s_valid) begin
            pre_cnt_d = pre_cnt_q + PRETRIG_W'(1);
            if (pre_cnt_d == pretrig_q) state_d = ARMED;
          end
        end
        ARMED: begin
          if (fire) begin
            hold_cnt_d = '0;
            state_d    = HOLDOFF;
          end
        end
        HOLDOFF: begin
          // Holdoff counts clocks; a zero holdoff still spends one cycle here.
          if ((holdoff_q == '0) || (hold_cnt_q == holdoff_q - HOLDOFF_W'(1))) begin
            state_d = rearm_q ? ARMED : IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLDOFF_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    trig_d   = fire;
    forced_d = fire && cfg_force;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      trig_q   <= 1'b0;
      forced_q <= 1'b0;
      count_q  <= '0;
    end else begin
      trig_q   <= trig_d;
      forced_q <= forced_d;
      if (fire) count_q <= count_q + 32'd1;
    end
  end

  assign trig_out    = trig_q;
  assign trig_forced = forced_q;
  assign state_out   = state_q;
  assign trig_count  = count_q;

endmodule

// File: tb/tb_adc_trigger_mc.sv
// Directed self-checking bench for adc_trigger_mc (NCH=4, SAMPLE_W=8).
module tb_adc_trigger_mc;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        cfg_arm = 1'b0, cfg_abort = 1'b0, cfg_force = 1'b0, cfg_rearm = 1'b0;
  logic [1:0]  cfg_channel = '0, cfg_edge = '0;
  logic [7:0]  cfg_level = '0, cfg_hyst = '0;
  logic [15:0] cfg_pretrig = '0;
  logic [23:0] cfg_holdoff = '0;
  logic        trig_out, trig_forced;
  logic [1:0]  state_out;
  logic [31:0] trig_count;

  int n_cmp = 0;
  int n_err = 0;

  adc_trigger_mc #(
    .NCH       (4),
    .SAMPLE_W  (8),
    .PRETRIG_W (16),
    .HOLDOFF_W (24)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .cfg_arm     (cfg_arm),
    .cfg_abort   (cfg_abort),
    .cfg_force   (cfg_force),
    .cfg_rearm   (cfg_rearm),
    .cfg_channel (cfg_channel),
    .cfg_edge    (cfg_edge),
    .cfg_level   (cfg_level),
    .cfg_hyst    (cfg_hyst),
    .cfg_pretrig (cfg_pretrig),
    .cfg_holdoff (cfg_holdoff),
    .trig_out    (trig_out),
    .trig_forced (trig_forced),
    .state_out   (state_out),
    .trig_count  (trig_count)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    s_valid = 1'b0; cfg_arm = 1'b0; cfg_abort = 1'b0; cfg_force = 1'b0;
    step();
    ARESETN = 1'b1;
  endtask

  task automatic put(input int ch, input logic [7:0] v, input logic [7:0] bg);
    s_data = {4{bg}};
    s_data[ch*8 +: 8] = v;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic arm(input logic [1:0] ch, input logic [1:0] edg, input logic [7:0] lvl,
                     input logic [7:0] hy, input logic [15:0] pre, input logic [23:0] hold,
                     input logic rr);
    cfg_channel = ch; cfg_edge = edg; cfg_level = lvl; cfg_hyst = hy;
    cfg_pretrig = pre; cfg_holdoff = hold; cfg_rearm = rr;
    cfg_arm = 1'b1;
    step();
    cfg_arm = 1'b0;
  endtask

  task automatic test_reset();
    #1 ARESETN = 1'b0;
    #2;
    n_cmp++; if (trig_out !== 1'b0) begin n_err++; $display("FAIL rst_trig got %b want 0", trig_out); end
    n_cmp++; if (trig_forced !== 1'b0) begin n_err++; $display("FAIL rst_forced got %b want 0", trig_forced); end
    n_cmp++; if (state_out !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", state_out); end
    n_cmp++; if (trig_count !== 32'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", trig_count); end
    step();
    ARESETN = 1'b1;
  endtask

  task automatic test_rising();
    int pulses = 0;
    do_reset();
    arm(2'd2, 2'd0, 8'h80, 8'h10, 16'd0, 24'd5, 1'b0);
    cfg_level = 8'hFF;  // must be ignored after arm
    n_cmp++; if (state_out !== 2'd2) begin n_err++; $display("FAIL t1_armed got %0d want 2", state_out); end
    put(2, 8'h70, 8'h00);
    put(2, 8'h78, 8'h00);
    n_cmp++; if (trig_out !== 1'b0) begin n_err++; $display("FAIL t1_early got %b want 0", trig_out); end
    put(2, 8'h80, 8'h00);
    n_cmp++; if (trig_out !== 1'b1) begin n_err++; $display("FAIL t1_trig got %b want 1", trig_out); end
    n_cmp++; if (trig_forced !== 1'b0) begin n_err++; $display("FAIL t1_forced got %b want 0", trig_forced); end
    n_cmp++; if (trig_count !== 32'd1) begin n_err++; $display("FAIL t1_count got %0d want 1", trig_count); end
    for (int i = 0; i < 4; i++) begin
      put(2, 8'h90, 8'h00);
      if (trig_out) pulses++;
    end
    n_cmp++; if (state_out !== 2'd3) begin n_err++; $display("FAIL t1_holdoff got %0d want 3", state_out); end
    put(2, 8'h90, 8'h00);
    if (trig_out) pulses++;
    n_cmp++; if (state_out !== 2'd0) begin n_err++; $display("FAIL t1_idle got %0d want 0", state_out); end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL t1_extra got %0d want 0", pulses); end
  endtask

  task automatic test_hysteresis();
    int pulses = 0;
    do_reset();
    arm(2'd2, 2'd0, 8'h80, 8'h10, 16'd0, 24'd0, 1'b1);
    put(2, 8'h7C, 8'h00);
    put(2, 8'h82, 8'h00);
    n_cmp++; if (trig_out !== 1'b1) begin n_err++; $display("FAIL t2_first got %b want 1", trig_out); end
    for (int i = 0; i < 3; i++) begin
      put(2, 8'h7C, 8'h00); if (trig_out) pulses++;
      put(2, 8'h82, 8'h00); if (trig_out) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL t2_chatter got %0d want 0", pulses); end
    put(2, 8'h60, 8'h00);
    n_cmp++; if (trig_out !== 1'b0) begin n_err++; $display("FAIL t2_fall got %b want 0", trig_out); end
    put(2, 8'h85, 8'h00);
    n_cmp++; if (trig_out !== 1'b1) begin n_err++; $display("FAIL t2_second got %b want 1", trig_out); end
    n_cmp++; if (trig_count !== 32'd2) begin n_err++; $display("FAIL t2_count got %0d want 2", trig_count); end
  endtask

  task automatic test_pretrig();
    do_reset();
    arm(2'd1, 2'd1, 8'h40, 8'h08, 16'd3, 24'd2, 1'b0);
    n_cmp++; if (state_out !== 2'd1) begin n_err++; $display("FAIL t3_pre0 got %0d want 1", state_out); end
    put(1, 8'h50, 8'h00);
    step(); step();  // idle beats must not advance the count
    n_cmp++; if (state_out !== 2'd1) begin n_err++; $display("FAIL t3_hold got %0d want 1", state_out); end
    put(1, 8'h20, 8'h00);
    n_cmp++; if (trig_out !== 1'b0) begin n_err++; $display("FAIL t3_ignored got %b want 0", trig_out); end
    n_cmp++; if (state_out !== 2'd1) begin n_err++; $display("FAIL t3_pre2 got %0d want 1", state_out); end
    put(1, 8'h50, 8'h00);
    n_cmp++; if (state_out !== 2'd2) begin n_err++; $display("FAIL t3_armed got %0d want 2", state_out); end
    put(1, 8'h30, 8'h00);
    n_cmp++; if (trig_out !== 1'b1) begin n_err++; $display("FAIL t3_trig got %b want 1", trig_out); end
    n_cmp++; if (state_out !== 2'd3) begin n_err++; $display("FAIL t3_hstate got %0d want 3", state_out); end
  endtask

  task automatic test_either_edge();
    int pulses = 0;
    do_reset();
    arm(2'd0, 2'd2, 8'h80, 8'h00, 16'd0, 24'd0, 1'b1);
    put(0, 8'h00, 8'hFF);
    n_cmp++; if (trig_out !== 1'b0) begin n_err++; $display("FAIL t4_init got %b want 0", trig_out); end
    put(0, 8'hFF, 8'h00);
    n_cmp++; if (trig_out !== 1'b1) begin n_err++; $display("FAIL t4_rise got %b want 1", trig_out); end
    step();
    put(0, 8'h00, 8'hFF);
    n_cmp++; if (trig_out !== 1'b1) begin n_err++; $display("FAIL t4_fall got %b want 1", trig_out); end
    step();
    for (int i = 0; i < 4; i++) begin
      put(0, 8'h00, (i % 2 == 0) ? 8'hFF : 8'h00);
      if (trig_out) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL t4_other got %0d want 0", pulses); end
    n_cmp++; if (trig_count !== 32'd2) begin n_err++; $display("FAIL t4_count got %0d want 2", trig_count); end
  endtask

  task automatic test_force();
    do_reset();
    arm(2'd3, 2'd0, 8'h80, 8'h10, 16'd0, 24'd0, 1'b1);
    put(3, 8'h10, 8'h00);
    cfg_force = 1'b1; step(); cfg_force = 1'b0;
    n_cmp++; if (trig_out !== 1'b1) begin n_err++; $display("FAIL t5_ftrig got %b want 1", trig_out); end
    n_cmp++; if (trig_forced !== 1'b1) begin n_err++; $display("FAIL t5_fflag got %b want 1", trig_forced); end
    step();
    n_cmp++; if (trig_forced !== 1'b0) begin n_err++; $display("FAIL t5_fclr got %b want 0", trig_forced); end
    s_data = 32'h9000_0000; s_valid = 1'b1; cfg_force = 1'b1;
    step();
    s_valid = 1'b0; cfg_force = 1'b0;
    n_cmp++; if ({trig_out, trig_forced} !== 2'b11) begin n_err++; $display("FAIL t5_both got %b want 11", {trig_out, trig_forced}); end
    n_cmp++; if (trig_count !== 32'd2) begin n_err++; $display("FAIL t5_count got %0d want 2", trig_count); end
    step();
    n_cmp++; if (trig_out !== 1'b0) begin n_err++; $display("FAIL t5_single got %b want 0", trig_out); end
    cfg_abort = 1'b1; step(); cfg_abort = 1'b0;
    cfg_force = 1'b1; step(); cfg_force = 1'b0;
    n_cmp++; if (trig_out !== 1'b0) begin n_err++; $display("FAIL t5_idle got %b want 0", trig_out); end
    n_cmp++; if (trig_count !== 32'd2) begin n_err++; $display("FAIL t5_icount got %0d want 2", trig_count); end
  endtask

  task automatic test_abort_reset();
    do_reset();
    arm(2'd0, 2'd0, 8'h80, 8'h00, 16'd0, 24'd100, 1'b0);
    put(0, 8'h00, 8'h00);
    put(0, 8'hFF, 8'h00);
    for (int i = 0; i < 49; i++) step();
    n_cmp++; if (state_out !== 2'd3) begin n_err++; $display("FAIL t6_mid got %0d want 3", state_out); end
    cfg_abort = 1'b1; step(); cfg_abort = 1'b0;
    n_cmp++; if (state_out !== 2'd0) begin n_err++; $display("FAIL t6_abort got %0d want 0", state_out); end
    cfg_abort = 1'b1; cfg_arm = 1'b1; step(); cfg_abort = 1'b0; cfg_arm = 1'b0;
    n_cmp++; if (state_out !== 2'd0) begin n_err++; $display("FAIL t6_armabort got %0d want 0", state_out); end
    arm(2'd0, 2'd0, 8'h80, 8'h00, 16'd0, 24'd100, 1'b0);
    put(0, 8'h00, 8'h00);
    n_cmp++; if (state_out !== 2'd2) begin n_err++; $display("FAIL t6_rearmed got %0d want 2", state_out); end
    #2 ARESETN = 1'b0;
    #1;
    n_cmp++; if (state_out !== 2'd0) begin n_err++; $display("FAIL t6_astate got %0d want 0", state_out); end
    n_cmp++; if (trig_count !== 32'd0) begin n_err++; $display("FAIL t6_acount got %0d want 0", trig_count); end
    n_cmp++; if ({trig_out, trig_forced} !== 2'b00) begin n_err++; $display("FAIL t6_aout got %b want 00", {trig_out, trig_forced}); end
    step();
    ARESETN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rising();
    test_hysteresis();
    test_pretrig();
    test_either_edge();
    test_force();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
